param_cpu: RTL and testbench

Parametrised multi-cycle accumulator-style CPU, the successor to the team's 8-bit teaching CPU. It adds configurable data and address width, four general registers, and full-word immediates and addresses. It also adds carry-in arithmetic, conditional branches and a halt state. It sits between a single-port memory (combinational read, write sampled on clock edge) and a top-level test harness, and executes programs from `RESET_VEC`.

---
 rtl/param_cpu_pkg.sv | 56 +++++
 rtl/param_cpu_if.sv | 18 +
 rtl/param_alu.sv | 34 +++
 rtl/param_cpu.sv | 147 ++++++++++++++
 tb/tb_param_cpu.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/param_cpu_pkg.sv
// Shared opcodes, condition codes and FSM state encoding for param_cpu.
package param_cpu_pkg;

  // ALU group occupies opcode high nibbles 0x0..0xA
  localparam logic [3:0] ALU_MOV = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_INC = 4'h3;
  localparam logic [3:0] ALU_DEC = 4'h4;
  localparam logic [3:0] ALU_ASL = 4'h5;
  localparam logic [3:0] ALU_LSR = 4'h6;
  localparam logic [3:0] ALU_OR  = 4'h7;
  localparam logic [3:0] ALU_AND = 4'h8;
  localparam logic [3:0] ALU_XOR = 4'h9;
  localparam logic [3:0] ALU_ADC = 4'hA;

  localparam logic [3:0] OP_LDI = 4'hB;
  localparam logic [3:0] OP_LD  = 4'hC;
  localparam logic [3:0] OP_ST  = 4'hD;
  localparam logic [3:0] OP_JCC = 4'hE;
  localparam logic [3:0] OP_SYS = 4'hF;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_Z      = 4'd1;
  localparam logic [3:0] COND_NZ     = 4'd2;
  localparam logic [3:0] COND_C      = 4'd3;
  localparam logic [3:0] COND_NC     = 4'd4;

  localparam logic [7:0] HLT    = 8'hF0;
  localparam logic [7:0] SRESET = 8'hFF;

  typedef enum logic [2:0] {
    RESET, FETCH, DECODE, OPERAND, LOAD, HALT
  } state_t;

  function automatic logic is_alu(input logic [3:0] op);
    return op <= ALU_ADC;
  endfunction

  // Condition codes above COND_NC are illegal and trap to soft reset.
  function automatic logic cond_legal(input logic [3:0] cond);
    return cond <= COND_NC;
  endfunction

  function automatic logic cond_ok(input logic [3:0] cond, input logic c, input logic z);
    case (cond)
      COND_ALWAYS: return 1'b1;
      COND_Z:      return z;
      COND_NZ:     return !z;
      COND_C:      return c;
      COND_NC:     return !c;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/param_cpu_if.sv
// Memory-side bus of param_cpu: registered address/store data and a store strobe.
interface param_cpu_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  // Read: data_in is the combinational memory word at address, valid the cycle
  // after address changes. Write: write is a one-cycle strobe; address and
  // data_out are stable through it and memory commits on its closing edge.
  // There is no back-pressure: memory is always ready.
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          write;
  logic          halted;

  modport master (output address, data_out, write, halted, input data_in);
  modport slave  (input address, data_out, write, halted, output data_in);
endinterface

// File: rtl/param_alu.sv
// Combinational ALU; y[DW] carries the carry/borrow/shifted-out bit.
module param_alu
  import param_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  logic [3:0]    aluop,
  output logic [DW:0]   y
);

  localparam logic [DW:0] ONE = (DW+1)'(1);

  always_comb begin
    y = '0;
    case (aluop)
      ALU_MOV: y = {1'b0, b};
      ALU_ADD: y = {1'b0, a} + {1'b0, b};
      ALU_SUB: y = {1'b0, a} - {1'b0, b};
      ALU_INC: y = {1'b0, a} + ONE;
      ALU_DEC: y = {1'b0, a} - ONE;
      ALU_ASL: y = {a, 1'b0};
      ALU_LSR: y = {a[0], 1'b0, a[DW-1:1]};
      ALU_OR:  y = {1'b0, a | b};
      ALU_AND: y = {1'b0, a & b};
      ALU_XOR: y = {1'b0, a ^ b};
      ALU_ADC: y = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/param_cpu.sv
// Multi-cycle accumulator-style CPU with four registers, C/Z flags and HALT.
module param_cpu
  import param_cpu_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            AW        = 8,
  parameter logic [AW-1:0] RESET_VEC = AW'('h80)
) (
  input  logic               clk,
  input  logic               reset,
  param_cpu_if.master        bus,
  output state_t             dbg_state,
  output logic               dbg_c,
  output logic               dbg_z,
  output logic [3:0][DW-1:0] dbg_regs
);

  state_t             state, state_nxt;
  logic [AW-1:0]      ip;
  logic [3:0][DW-1:0] regs;
  logic [7:0]         opcode;
  logic               c, z;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      dout_q;
  logic               write_q, halted_q;

  // Fields of the word on data_in during DECODE, and of the latched opcode later.
  logic [3:0] op_in, op_q;
  logic [1:0] rd_in, rs_in, rd_q;
  logic [3:0] cond_in, cond_q;
  logic [DW:0] alu_y;

  assign op_in   = bus.data_in[7:4];
  assign rd_in   = bus.data_in[3:2];
  assign rs_in   = bus.data_in[1:0];
  assign cond_in = bus.data_in[3:0];
  assign op_q    = opcode[7:4];
  assign rd_q    = opcode[3:2];
  assign cond_q  = opcode[3:0];

  param_alu #(.DW(DW)) u_alu (
    .a     (regs[rd_in]),
    .b     (regs[rs_in]),
    .cin   (c),
    .aluop (op_in),
    .y     (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET:  state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        if (is_alu(op_in))
          state_nxt = FETCH;
        else if (op_in == OP_LDI || op_in == OP_LD || op_in == OP_ST)
          state_nxt = OPERAND;
        else if (op_in == OP_JCC)
          state_nxt = cond_legal(cond_in) ? OPERAND : RESET;
        else if (bus.data_in[7:0] == HLT)
          state_nxt = HALT;
        else
          state_nxt = RESET;
      end
      OPERAND: state_nxt = (op_q == OP_LD) ? LOAD : FETCH;
      LOAD:    state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ip       <= RESET_VEC;
      regs     <= '0;
      opcode   <= '0;
      c        <= 1'b0;
      z        <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      write_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        // Soft reset path: address and halted are deliberately left alone.
        RESET: begin
          ip      <= RESET_VEC;
          regs    <= '0;
          c       <= 1'b0;
          z       <= 1'b0;
          dout_q  <= '0;
          write_q <= 1'b0;
        end
        FETCH: begin
          addr_q  <= ip;
          ip      <= ip + AW'(1);
          write_q <= 1'b0;
        end
        DECODE: begin
          opcode <= bus.data_in[7:0];
          if (is_alu(op_in)) begin
            regs[rd_in] <= alu_y[DW-1:0];
            c           <= alu_y[DW];
            z           <= ~|alu_y[DW-1:0];
          end
          if (state_nxt == OPERAND) begin
            addr_q <= ip;
            ip     <= ip + AW'(1);
          end
          if (state_nxt == HALT) halted_q <= 1'b1;
        end
        OPERAND: begin
          case (op_q)
            OP_LDI: regs[rd_q] <= bus.data_in;
            OP_LD:  addr_q <= bus.data_in[AW-1:0];
            OP_ST: begin
              addr_q  <= bus.data_in[AW-1:0];
              dout_q  <= regs[rd_q];
              write_q <= 1'b1;
            end
            OP_JCC: if (cond_ok(cond_q, c, z)) ip <= bus.data_in[AW-1:0];
            default: ;
          endcase
        end
        LOAD: regs[rd_q] <= bus.data_in;
        default: ;
      endcase
    end
  end

  assign bus.address  = addr_q;
  assign bus.data_out = dout_q;
  assign bus.write    = write_q;
  assign bus.halted   = halted_q;

  assign dbg_state = state;
  assign dbg_c     = c;
  assign dbg_z     = z;
  assign dbg_regs  = regs;

endmodule

// File: tb/tb_param_cpu.sv
// Directed programs on an 8-bit and a 16/12-bit param_cpu; stores are scoreboarded.
module tb_param_cpu;
  import param_cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- DUTs and memories ----------------
  param_cpu_if #(.DW(8),  .AW(8))  bus_a ();
  param_cpu_if #(.DW(16), .AW(12)) bus_b ();

  state_t            st_a, st_b;
  logic              c_a, z_a, c_b, z_b;
  logic [3:0][7:0]   regs_a;
  logic [3:0][15:0]  regs_b;

  param_cpu #(.DW(8), .AW(8), .RESET_VEC(8'h80)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a),
    .dbg_state(st_a), .dbg_c(c_a), .dbg_z(z_a), .dbg_regs(regs_a)
  );

  param_cpu #(.DW(16), .AW(12), .RESET_VEC(12'h080)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b),
    .dbg_state(st_b), .dbg_c(c_b), .dbg_z(z_b), .dbg_regs(regs_b)
  );

  logic [7:0]  mem_a [256];
  logic [15:0] mem_b [4096];
  logic        pa_en = 1'b0, pb_en = 1'b0;
  logic [7:0]  pa_addr, pa_data;
  logic [11:0] pb_addr;
  logic [15:0] pb_data;

  assign bus_a.data_in = mem_a[bus_a.address];
  assign bus_b.data_in = mem_b[bus_b.address];

  always @(posedge clk) begin
    if (pa_en) mem_a[pa_addr] <= pa_data;
    else if (bus_a.write) mem_a[bus_a.address] <= bus_a.data_out;
    if (pb_en) mem_b[pb_addr] <= pb_data;
    else if (bus_b.write) mem_b[bus_b.address] <= bus_b.data_out;
  end

  // ---------------- driver tasks ----------------
  task automatic poke_a(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); pa_en = 1'b1; pa_addr = a; pa_data = d;
    @(negedge clk); pa_en = 1'b0;
  endtask

  task automatic poke_b(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk); pb_en = 1'b1; pb_addr = a; pb_data = d;
    @(negedge clk); pb_en = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_dec_a(input logic [7:0] a, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (st_a == DECODE && bus_a.address == a) begin
        at = cyc;
        break;
      end
    end
    check($sformatf("reach_decode_%h", a), 32'(at >= 0), 32'd1);
  endtask

  task automatic hard_reset_a();
    @(negedge clk); reset_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state",   32'(st_a), 32'(RESET));
    check("rst_address", 32'(bus_a.address), 32'h0);
    check("rst_write",   32'(bus_a.write), 32'h0);
    check("rst_halted",  32'(bus_a.halted), 32'h0);
    check("rst_regs",    regs_a, 32'h0);
    check("rst_flags",   32'({c_a, z_a}), 32'h0);
    reset_a = 1'b0;
    @(negedge clk); check("first_fetch", 32'(st_a), 32'(FETCH));
    @(negedge clk); check("fetch_vec",   32'(bus_a.address), 32'h80);
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  initial forever begin
    @(negedge clk);
    if (bus_a.write === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        total++; bad++;
        $display("FAIL store_a_unexpected: got addr %0h data %0h expected none", bus_a.address, bus_a.data_out);
      end else
        check("store_a", {16'(bus_a.address), 16'(bus_a.data_out)}, exp_a_q.pop_front());
    end
    if (bus_b.write === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        total++; bad++;
        $display("FAIL store_b_unexpected: got addr %0h data %0h expected none", bus_b.address, bus_b.data_out);
      end else
        check("store_b", {16'(bus_b.address), bus_b.data_out}, exp_b_q.pop_front());
    end
  end

  // ---------------- programs ----------------
  logic [7:0] prog_a [56] = '{
    8'hB0, 8'h1F, 8'h50, 8'h50, 8'h50, 8'h50, 8'hD0, 8'h01,  // 80
    8'hB4, 8'hFF, 8'hB8, 8'h01, 8'h16, 8'hE1, 8'h90, 8'hF0,  // 88
    8'hAA, 8'hD8, 8'h02, 8'h15, 8'hE2, 8'hA0, 8'hBC, 8'h5A,  // 90
    8'hDC, 8'h04, 8'h2E, 8'h6C, 8'hE3, 8'hA0, 8'hF0, 8'hF0,  // 98
    8'hDC, 8'h05, 8'h44, 8'hD4, 8'h06, 8'hE4, 8'hA0, 8'h7C,  // A0
    8'h8E, 8'h9D, 8'hDC, 8'h07, 8'h34, 8'h0B, 8'hC4, 8'h02,  // A8
    8'h16, 8'hD4, 8'h08, 8'hE0, 8'hB7, 8'hF0, 8'hF0, 8'hF0   // B0
  };

  // {address, word}; 0xFFF doubles as LD data and as INC r1 reached by ip wrap
  logic [27:0] prog_b [16] = '{
    {12'h080, 16'h00BC}, {12'h081, 16'h8000}, {12'h082, 16'hAB5C}, {12'h083, 16'h00DC},
    {12'h084, 16'h0010}, {12'h085, 16'h00C0}, {12'h086, 16'h0FFF}, {12'h087, 16'h00E0},
    {12'h088, 16'h0FFF}, {12'h089, 16'h00F0}, {12'hFFF, 16'h1234}, {12'h000, 16'h00D4},
    {12'h001, 16'h0011}, {12'h002, 16'h00D0}, {12'h003, 16'h0012}, {12'h004, 16'h00F0}
  };

  // ---------------- main sequence ----------------
  initial begin
    int t0, t1, t_dummy;
    bit seen;

    for (int i = 0; i < 56; i++) poke_a(8'(8'h80 + i), prog_a[i]);
    for (int i = 0; i < 16; i++) poke_b(prog_b[i][27:16], prog_b[i][15:0]);

    exp_a_q.push_back({16'h0001, 16'h00F0});
    exp_a_q.push_back({16'h0002, 16'h0003});
    exp_a_q.push_back({16'h0004, 16'h005A});
    exp_a_q.push_back({16'h0005, 16'h002B});
    exp_a_q.push_back({16'h0006, 16'h00FF});
    exp_a_q.push_back({16'h0007, 16'h00FC});
    exp_a_q.push_back({16'h0008, 16'h00FF});

    hard_reset_a();
    wait_dec_a(8'h82, t0);
    wait_dec_a(8'h83, t1);
    check("alu_cycles", 32'(t1 - t0), 32'd2);
    wait_dec_a(8'h86, t0);
    check("asl_r0", 32'(regs_a[0]), 32'hF0);
    check("asl_flags_cz", 32'({c_a, z_a}), 32'b10);
    wait_dec_a(8'h88, t1);
    check("st_cycles", 32'(t1 - t0), 32'd3);
    wait_dec_a(8'h8D, t0);
    check("add_r1", 32'(regs_a[1]), 32'h00);
    check("add_flags_cz", 32'({c_a, z_a}), 32'b11);
    wait_dec_a(8'h90, t1);
    check("jz_taken_cycles", 32'(t1 - t0), 32'd3);
    wait_dec_a(8'h94, t0);
    check("jnz_z_set", 32'(z_a), 32'd1);
    wait_dec_a(8'h96, t1);
    check("jnz_not_taken_cycles", 32'(t1 - t0), 32'd3);
    wait_dec_a(8'hAE, t0);
    wait_dec_a(8'hB0, t1);
    check("ld_cycles", 32'(t1 - t0), 32'd4);

    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus_a.halted;
    end
    check("halt_reached", 32'(seen), 32'd1);
    check("halt_address", 32'(bus_a.address), 32'hB7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_frozen_addr", 32'(bus_a.address), 32'hB7);
      check("halt_flag", 32'(bus_a.halted), 32'd1);
    end

    // Soft reset via illegal opcode 0xF5
    reset_a = 1'b1;
    poke_a(8'h80, 8'hB0); poke_a(8'h81, 8'h77); poke_a(8'h82, 8'hF5);
    hard_reset_a();
    wait_dec_a(8'h82, t_dummy);
    check("ldi_before_sreset", 32'(regs_a[0]), 32'h77);
    @(negedge clk); check("sreset_state", 32'(st_a), 32'(RESET));
    @(negedge clk); check("sreset_regs", regs_a, 32'h0);
    check("sreset_halted", 32'(bus_a.halted), 32'h0);
    check("sreset_fetch", 32'(st_a), 32'(FETCH));
    @(negedge clk); check("sreset_vec", 32'(bus_a.address), 32'h80);

    // Hard reset landing on a store's write cycle
    reset_a = 1'b1;
    poke_a(8'h81, 8'h3C); poke_a(8'h82, 8'hD0); poke_a(8'h83, 8'h09); poke_a(8'h84, 8'hF0);
    exp_a_q.push_back({16'h0009, 16'h003C});
    hard_reset_a();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus_a.write;
    end
    check("write_seen", 32'(seen), 32'd1);
    reset_a = 1'b1;
    @(negedge clk);
    check("write_low_after_reset", 32'(bus_a.write), 32'd0);
    check("write_committed", 32'(mem_a[9]), 32'h3C);

    // Wide instance: DW=16, AW=12
    exp_b_q.push_back({16'h0010, 16'h0000});
    exp_b_q.push_back({16'h0011, 16'h0001});
    exp_b_q.push_back({16'h0012, 16'h1234});
    @(negedge clk); reset_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (st_b == DECODE) && (bus_b.address == 12'h083);
    end
    check("b_reach_083", 32'(seen), 32'd1);
    check("b_asl_r3", 32'(regs_b[3]), 32'h0);
    check("b_asl_flags_cz", 32'({c_b, z_b}), 32'b11);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus_b.halted;
    end
    check("b_halt_reached", 32'(seen), 32'd1);
    check("b_halt_address", 32'(bus_b.address), 32'h004);
    check("b_ld_r0", 32'(regs_b[0]), 32'h1234);

    repeat (3) @(negedge clk);
    check("queue_a_drained", 32'(exp_a_q.size()), 32'd0);
    check("queue_b_drained", 32'(exp_b_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
